// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and the shared axis phase enum
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter, phase FSM, registered sync
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY  = 640,
    parameter int FRONT    = 16,
    parameter int SYNC     = 96,
    parameter int BACK     = 48,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic [POS_W-1:0] pos_o,
    output logic             wrap_o,
    output logic             active_d_o,
    output logic             sync_o
);

    localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

    if (TOTAL > 1024) begin : g_bad_params
        $error("vga_axis_counter: axis total exceeds the 10-bit position range");
    end

    localparam logic [POS_W-1:0] LAST       = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] ACT_LAST   = POS_W'(DISPLAY - 1);
    localparam logic [POS_W-1:0] FRONT_LAST = POS_W'(DISPLAY + FRONT - 1);
    localparam logic [POS_W-1:0] SYNC_LAST  = POS_W'(DISPLAY + FRONT + SYNC - 1);

    logic [POS_W-1:0] pos_q, pos_d;
    phase_e           phase_q, phase_d;
    logic             sync_q;

    always_comb begin
        pos_d   = pos_q;
        phase_d = phase_q;
        if (en_i) begin
            pos_d = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
            // Phase advances on the last count of the current phase
            case (phase_q)
                PH_ACTIVE: if (pos_q == ACT_LAST)   phase_d = PH_FRONT;
                PH_FRONT:  if (pos_q == FRONT_LAST) phase_d = PH_SYNC;
                PH_SYNC:   if (pos_q == SYNC_LAST)  phase_d = PH_BACK;
                PH_BACK:   if (pos_q == LAST)       phase_d = PH_ACTIVE;
                default:                            phase_d = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pos_q   <= '0;
            phase_q <= PH_ACTIVE;
            sync_q  <= SYNC_NEG;
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
            sync_q  <= (phase_d == PH_SYNC) ^ SYNC_NEG;
        end
    end

    assign pos_o      = pos_q;
    assign wrap_o     = en_i && (pos_q == LAST);
    assign active_d_o = (phase_d == PH_ACTIVE);
    assign sync_o     = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_TIMING_FRAME_CNT_EN enables frame_cnt
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit HSYNC_NEG = 1'b1,
    parameter bit VSYNC_NEG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start,
    output logic [7:0]       frame_cnt
);

    localparam logic [POS_W-1:0] V_DISP_LAST = POS_W'(V_DISPLAY - 1);

    logic h_wrap, v_wrap, h_active_d, v_active_d;
    logic display_on_q, line_start_q, frame_start_q, vblank_start_q;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .SYNC_NEG(HSYNC_NEG)
    ) u_h_axis (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (1'b1),
        .pos_o     (hpos),
        .wrap_o    (h_wrap),
        .active_d_o(h_active_d),
        .sync_o    (hsync)
    );

    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .SYNC_NEG(VSYNC_NEG)
    ) u_v_axis (
        .clk_i     (clk),
        .reset_i   (reset),
        .en_i      (h_wrap),
        .pos_o     (vpos),
        .wrap_o    (v_wrap),
        .active_d_o(v_active_d),
        .sync_o    (vsync)
    );

    // Strobes decode the wrap that produces the next position, so they line up with hpos/vpos
    always_ff @(posedge clk) begin
        if (reset) begin
            display_on_q   <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            display_on_q   <= h_active_d && v_active_d;
            line_start_q   <= h_wrap;
            frame_start_q  <= v_wrap;
            vblank_start_q <= h_wrap && (vpos == V_DISP_LAST);
        end
    end

    assign display_on   = display_on_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench: full 640x480 instance plus a tiny-raster instance
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rb, rs;
    logic [9:0] b_hpos, b_vpos, s_hpos, s_vpos;
    logic       b_hsync, b_vsync, b_disp, b_ls, b_fs, b_vb;
    logic       s_hsync, s_vsync, s_disp, s_ls, s_fs, s_vb;
    logic [7:0] b_fc, s_fc;

    vga_timing_gen u_big (
        .clk(clk), .reset(rb), .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
        .display_on(b_disp), .line_start(b_ls), .frame_start(b_fs), .vblank_start(b_vb),
        .frame_cnt(b_fc)
    );

    // Tiny raster: 8 columns (4 visible, sync at 5..6), 7 lines (3 visible, sync at 4)
    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .HSYNC_NEG(1'b0), .VSYNC_NEG(1'b1)
    ) u_small (
        .clk(clk), .reset(rs), .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
        .display_on(s_disp), .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb),
        .frame_cnt(s_fc)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int bh = 0, bv = 0, sh = 0, sv = 0, sfc = 0;
    int bbad = 0, sbad = 0;
    int b_last_ls = -1, b_ls_period = 0;
    int s_last_fs = -1, s_fs_period = 0, s_first_fs = -1, rel_cyc = 0;
    int s_fc_max = 0;
    logic [7:0] s_fc_prev = 8'd0;
    int seen_wrap = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance both reference rasters and tally any output disagreement
    task automatic step();
        logic rb_s, rs_s;
        rb_s = rb;
        rs_s = rs;
        @(posedge clk);
        #1;
        cyc++;
        if (rb_s) begin
            bh = 0; bv = 0;
        end else begin
            bh = (bh + 1) % 800;
            if (bh == 0) bv = (bv + 1) % 525;
        end
        if (b_hpos !== 10'(bh) || b_vpos !== 10'(bv)) bbad++;
        if (b_disp !== (!rb_s && bh < 640 && bv < 480)) bbad++;
        if (b_hsync !== (rb_s || !(bh >= 656 && bh <= 751))) bbad++;
        if (b_vsync !== (rb_s || !(bv >= 490 && bv <= 491))) bbad++;
        if (b_ls !== (!rb_s && bh == 0)) bbad++;
        if (b_fs !== (!rb_s && bh == 0 && bv == 0)) bbad++;
        if (b_vb !== (!rb_s && bh == 0 && bv == 480)) bbad++;

        if (rs_s) begin
            sh = 0; sv = 0; sfc = 0;
        end else begin
            sh = (sh + 1) % 8;
            if (sh == 0) sv = (sv + 1) % 7;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (sh == 0 && sv == 0) sfc = (sfc + 1) % 256;
`endif
        end
        if (s_hpos !== 10'(sh) || s_vpos !== 10'(sv)) sbad++;
        if (s_disp !== (!rs_s && sh < 4 && sv < 3)) sbad++;
        if (s_hsync !== (!rs_s && sh >= 5 && sh <= 6)) sbad++;
        if (s_vsync !== (rs_s || sv != 4)) sbad++;
        if (s_ls !== (!rs_s && sh == 0)) sbad++;
        if (s_fs !== (!rs_s && sh == 0 && sv == 0)) sbad++;
        if (s_vb !== (!rs_s && sh == 0 && sv == 3)) sbad++;
        if (s_fc !== 8'(sfc)) sbad++;

        if (b_ls === 1'b1) begin
            if (b_last_ls >= 0) b_ls_period = cyc - b_last_ls;
            b_last_ls = cyc;
        end
        if (s_fs === 1'b1) begin
            if (s_last_fs >= 0) s_fs_period = cyc - s_last_fs;
            s_last_fs = cyc;
            if (s_first_fs < 0) s_first_fs = cyc;
        end
        if (int'(s_fc) > s_fc_max) s_fc_max = int'(s_fc);
        if (s_fc_prev == 8'd255 && s_fc == 8'd0 && !rs_s) seen_wrap++;
        s_fc_prev = s_fc;
    endtask

    initial begin
        rb = 1'b1;
        rs = 1'b1;
        step(); step(); step();
        check("reset_hpos", int'(b_hpos), 0);
        check("reset_vpos", int'(b_vpos), 0);
        check("reset_display_on", int'(b_disp), 0);
        check("reset_hsync_inactive", int'(b_hsync), 1);
        check("reset_vsync_inactive", int'(b_vsync), 1);
        check("reset_line_start", int'(b_ls), 0);
        check("reset_small_hsync_inactive", int'(s_hsync), 0);
        check("reset_frame_cnt", int'(s_fc), 0);

        rb = 1'b0;
        rs = 1'b0;
        step();
        rel_cyc = cyc;
        check("first_edge_hpos", int'(b_hpos), 1);
        check("first_edge_vpos", int'(b_vpos), 0);
        check("first_edge_display_on", int'(b_disp), 1);
        check("first_edge_small_hpos", int'(s_hpos), 1);

        for (int i = 0; i < 1700; i++) step();
        check("big_raster_rows_0_2", bbad, 0);
        check("line_start_period", b_ls_period, 800);
        check("small_raster_frames", sbad, 0);
        check("frame_start_period", s_fs_period, 56);
        check("first_frame_start_latency", s_first_fs - rel_cyc, 55);

        for (int i = 0; i < 64 && !(sh == 3 && sv == 2); i++) step();
        check("small_display_last_pixel", int'(s_disp), 1);
        step();
        check("small_display_first_blank_col", int'(s_disp), 0);
        for (int i = 0; i < 64 && !(sh == 0 && sv == 3); i++) step();
        check("small_display_first_blank_line", int'(s_disp), 0);
        check("small_vblank_start", int'(s_vb), 1);

        for (int i = 0; i < 800 && bh != 300; i++) step();
        check("reached_hpos_300", int'(b_hpos), 300);
        rb = 1'b1;
        rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_reset_hpos", int'(b_hpos), 0);
            check("mid_reset_strobes", int'({b_ls, b_fs, b_vb, b_disp, s_ls, s_fs, s_vb}), 0);
        end
        rb = 1'b0;
        rs = 1'b0;
        s_first_fs = -1;
        s_last_fs = -1;
        step();
        rel_cyc = cyc;
        check("after_reset_hpos", int'(b_hpos), 1);
        check("after_reset_vpos", int'(b_vpos), 0);
        check("after_reset_small_pos", int'({s_hpos, s_vpos}), int'({10'd1, 10'd0}));

        for (int i = 0; i < 14400; i++) step();
        check("small_first_frame_start_after_reset", s_first_fs - rel_cyc, 55);
        check("small_raster_256_frames", sbad, 0);
        check("big_raster_overall", bbad, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check("frame_cnt_wrap_255_to_0", seen_wrap, 1);
`else
        check("frame_cnt_tied_zero", s_fc_max, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_DISPLAY 640 (active pixels per line); H_FRONT 16; H_SYNC 96; H_BACK 48; V_DISPLAY 480 (active lines); V_FRONT 10; V_SYNC 2; V_BACK 33; HSYNC_NEG 1 (1 = hsync active-low); VSYNC_NEG 1 (1 = vsync active-low).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-003 SHALL have ports: clk  in  1  pixel clock; reset  in  1  sync active-high reset.
REQ-004 SHALL have ports: hpos  out  10  current column; vpos  out  10  current line.
REQ-005 SHALL have ports: hsync  out  1; vsync  out  1; display_on  out  1  pixel visible.
REQ-006 SHALL have ports: line_start  out  1  one-cycle pulse; frame_start  out  1  one-cycle pulse; vblank_start  out  1  one-cycle pulse; frame_cnt  out  8  completed-frame count.

Function
REQ-007 SHALL run hpos from 0 to H_TOTAL-1 (H_TOTAL = sum of H_* = 800), then wrap to 0.
REQ-008 SHALL increment vpos only on the hpos wrap, from 0 to V_TOTAL-1 (525), then wrap to 0.
REQ-009 SHALL track the horizontal phase in an FSM: H_ACTIVE (hpos < H_DISPLAY) -> H_FRONT -> H_SYNC -> H_BACK -> H_ACTIVE, with each transition at the phase-boundary count.
REQ-010 SHALL track the vertical phase in an FSM with states V_ACTIVE/V_FRONT/V_SYNC/V_BACK, advanced only on the hpos wrap.
REQ-011 SHALL register hsync, vsync, display_on and all strobes, each decoded from next-counter values, so every output is aligned with the hpos/vpos of the same cycle (zero relative latency).
REQ-012 SHALL assert hsync for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), with polarity per HSYNC_NEG; vsync SHALL follow the same rule on vpos (490..491), with polarity per VSYNC_NEG.
REQ-013 SHALL drive display_on = 1 iff hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-014 SHALL pulse line_start for exactly one cycle when hpos==0.
REQ-015 SHALL pulse frame_start for exactly one cycle when hpos==0 and vpos==0.
REQ-016 SHALL pulse vblank_start for exactly one cycle when hpos==0 and vpos==V_DISPLAY; downstream motion logic updates on this pulse, never on a vsync edge.
REQ-017 SHALL increment frame_cnt (modulo 256, 255 -> 0) in the same cycle that frame_start is asserted.
REQ-018 SHALL make hpos and vpos 10-bit unsigned; parameter sums above 1024 SHALL be a parameter error.

Reset
REQ-019 SHALL, while reset is high, hold: hpos=0, vpos=0, both FSMs in ACTIVE, display_on=0, hsync/vsync inactive, all strobes 0, frame_cnt=0.
REQ-020 SHALL, on the first edge with reset low, move the counters to (1,0) and decode the outputs for (1,0); the first frame_start SHALL follow H_TOTAL*V_TOTAL-1 cycles later.
REQ-021 SHALL abandon the current line/frame immediately on reset asserted mid-frame, emitting no partial strobes.

Configuration
REQ-022 SHALL, when VGA_TIMING_FRAME_CNT_EN is defined, implement the frame_cnt register per REQ-017.
REQ-023 SHALL, when VGA_TIMING_FRAME_CNT_EN is undefined, tie frame_cnt to 8'd0 with no register present; all other behaviour is unchanged.

Structure
REQ-024 SHALL place the 640x480@60 timing constants, the derived H_TOTAL/V_TOTAL, and the phase enum (ACTIVE/FRONT/SYNC/BACK) in shared package vga_timing_pkg.
REQ-025 SHALL instantiate sub-module vga_axis_counter (counter, phase FSM and sync decode for one axis) twice: horizontal, then vertical with the hpos wrap as enable.

Verification
REQ-026 SHALL verify: release reset, count 800 cycles -> line_start period 800; hsync low exactly at hpos 656..751.
REQ-027 SHALL verify: run 420000 cycles -> frame_start period 420000; vsync low only at vpos 490..491; vblank_start at (0,480) once per frame.
REQ-028 SHALL verify: at (639,479) display_on=1; at (640,479) display_on=0; at (0,480) display_on=0.
REQ-029 SHALL verify: assert reset for 3 cycles at (300,200) -> outputs at reset values in those cycles; the next cycle is at (1,0); no frame_start until the wrap.
REQ-030 SHALL verify: run 256 frames with the macro defined -> frame_cnt goes 255 -> 0; without the macro, frame_cnt stays 0.
REQ-031 SHALL verify: HSYNC_NEG=0 -> hsync high only at hpos 656..751.
